adc_readout_scheduler: RTL

ADC_READOUT_SCHEDULER -- requirements
Module: adc_readout_scheduler

---
 rtl/adc_readout_scheduler_pkg.sv | 25 ++
 rtl/adc_readout_scheduler_eoc.sv | 41 ++++
 rtl/adc_readout_scheduler.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/adc_readout_scheduler_pkg.sv
// Shared definitions for the ADC readout scheduler: defaults, widths, FSM encoding
// and the output beat payload.
package adc_readout_scheduler_pkg;

    localparam int unsigned NUM_CH_DEF  = 128;
    localparam int unsigned CAP_DLY_DEF = 4;
    localparam int unsigned CH_W        = $clog2(NUM_CH_DEF);
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned FRAME_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic               last;
        logic [FRAME_W-1:0] frame;
        logic [CH_W-1:0]    chan;
        logic [DATA_W-1:0]  data;
    } beat_t;

endpackage

// File: rtl/adc_readout_scheduler_eoc.sv
// End-of-conversion detector: a low sample of adc_reset followed by CAP_DLY
// consecutive high samples; eoc is high during the CAP_DLY-th high cycle.
module adc_eoc_detect
    import adc_readout_scheduler_pkg::*;
#(
    parameter int unsigned CAP_DLY = CAP_DLY_DEF
) (
    input  logic clk,
    input  logic n_reset,
    input  logic arm,
    input  logic adc_reset,
    output logic eoc
);

    localparam int unsigned CNT_W = $clog2(CAP_DLY + 1);

    logic             low_seen;
    logic [CNT_W-1:0] high_cnt;

    assign eoc = arm & low_seen & adc_reset & (high_cnt == CNT_W'(CAP_DLY - 1));

    // Disarming forgets any partial conversion, so the first high period after enable never fires
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            low_seen <= 1'b0;
            high_cnt <= '0;
        end else if (!arm) begin
            low_seen <= 1'b0;
            high_cnt <= '0;
        end else if (!adc_reset) begin
            low_seen <= 1'b1;
            high_cnt <= '0;
        end else if (eoc) begin
            low_seen <= 1'b0;
            high_cnt <= '0;
        end else if (low_seen) begin
            high_cnt <= high_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/adc_readout_scheduler.sv
// Sequences ADC conversions, captures each completed frame into a single buffer
// and streams it out one channel per handshake.
module adc_readout_scheduler
    import adc_readout_scheduler_pkg::*;
#(
    parameter int unsigned NUM_CH  = NUM_CH_DEF,
    parameter int unsigned CAP_DLY = CAP_DLY_DEF
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic [FRAME_W-1:0]       num_frames,
    input  logic                     adc_reset,
    input  logic [DATA_W*NUM_CH-1:0] adc_result,
    output logic                     adc_enable,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_chan,
    output logic [FRAME_W-1:0]       out_frame,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_t                         state, state_n;
    beat_t                          beat, beat_n;
    logic [NUM_CH-1:0][DATA_W-1:0]  frame_buf, frame_buf_n;
    logic                           valid_n;
    logic [FRAME_W-1:0]             target, target_n;
    logic [FRAME_W-1:0]             captured, captured_n;
    logic                           enable_n, busy_n, done_n, overrun_n;
    logic                           eoc, hs, last_hs, eoc_run, buf_free, capture;
    logic [CH_W-1:0]                nxt_chan;

    adc_eoc_detect #(
        .CAP_DLY (CAP_DLY)
    ) u_eoc (
        .clk       (clk),
        .n_reset   (n_reset),
        .arm       (adc_enable),
        .adc_reset (adc_reset),
        .eoc       (eoc)
    );

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        beat_n      = beat;
        frame_buf_n = frame_buf;
        valid_n     = out_valid;
        target_n    = target;
        captured_n  = captured;
        overrun_n   = overrun;

        hs       = out_valid & out_ready;
        last_hs  = hs & beat.last;
        eoc_run  = eoc & (state == ST_RUN);
        buf_free = ~out_valid | last_hs;
        capture  = eoc_run & buf_free;
        nxt_chan = beat.chan + 1'b1;

        if (hs) begin
            if (beat.last) begin
                valid_n     = 1'b0;
                beat_n.chan = '0;
                beat_n.last = 1'b0;
                beat_n.frame = beat.frame + 1'b1;
            end else begin
                beat_n.chan = nxt_chan;
                beat_n.data = frame_buf[nxt_chan];
                beat_n.last = (nxt_chan == LAST_CH);
            end
        end

        // A capture may reuse the buffer in the same cycle its last beat leaves
        if (capture) begin
            frame_buf_n = adc_result;
            valid_n     = 1'b1;
            beat_n.chan = '0;
            beat_n.data = adc_result[DATA_W-1:0];
            beat_n.last = (NUM_CH == 1);
            captured_n  = captured + 1'b1;
        end else if (eoc_run) begin
            overrun_n = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n    = ST_RUN;
                    target_n   = num_frames;
                    captured_n = '0;
                    overrun_n  = 1'b0;
                    beat_n     = '0;
                end
            end
            ST_RUN: begin
                if (stop || (capture && (target != '0) && (captured_n == target))) begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!out_valid) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase

        enable_n = (state == ST_RUN);
        busy_n   = (state_n == ST_RUN) || (state_n == ST_DRAIN);
        done_n   = (state_n == ST_DONE);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            beat       <= '0;
            out_valid  <= 1'b0;
            target     <= '0;
            captured   <= '0;
            adc_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            beat       <= beat_n;
            out_valid  <= valid_n;
            target     <= target_n;
            captured   <= captured_n;
            adc_enable <= enable_n;
            busy       <= busy_n;
            done       <= done_n;
            overrun    <= overrun_n;
        end
    end

    // Frame storage carries no reset; it is only read while out_valid is set
    always_ff @(posedge clk) begin
        frame_buf <= frame_buf_n;
    end

    assign out_data  = beat.data;
    assign out_chan  = beat.chan;
    assign out_frame = beat.frame;
    assign out_last  = beat.last;

endmodule
